// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver
//   Display-side end of the OLED SPI link. Oversamples sck/mosi/cs/dc/res on
//   the system clock, assembles MSB-first bytes, decodes the SSD1306-style
//   command subset (display on/off, addressing mode, column/page windows) and
//   turns data bytes into framebuffer writes with address auto-increment.
//
// Ports
//   clk, reset     system clock, asynchronous active-low reset
//   sck, mosi      SPI mode 0 clock and data (MSB first)
//   cs, dc, res    chip select (low), data/command select, panel reset (low)
//   byte_valid     one-cycle strobe per completed byte
//   byte_data      completed byte, held until the next strobe
//   byte_is_data   dc value captured with byte_data
//   fb_we          one-cycle framebuffer write strobe
//   fb_addr        page*COLS + col
//   fb_wdata       write data, bit 0 = top pixel row of the page
//   display_on     set by 0xAF, cleared by 0xAE
//   addr_mode      0 horizontal, 1 vertical, 2 page
//   frame_done     one-cycle strobe after the write that wraps the pointer
//                  back to (col_start, page_start)

module oled_spi_receiver #(
  parameter int COLS        = 128,
  parameter int PAGES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = $clog2(COLS * PAGES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          mosi,
  input  logic          cs,
  input  logic          dc,
  input  logic          res,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_is_data,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [7:0]    fb_wdata,
  output logic          display_on,
  output logic [1:0]    addr_mode,
  output logic          frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  // Synchronizer lane order: {res, dc, cs, mosi, sck}; cs idles high.
  localparam logic [4:0] SYNC_RST = 5'b00100;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_ARG1,
    ST_ARG2
  } state_e;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic sck_prev_q;
  logic sck_s, mosi_s, cs_s, dc_s, res_s;
  logic sck_rise;

  assign sck_s  = sync_q[SYNC_STAGES-1][0];
  assign mosi_s = sync_q[SYNC_STAGES-1][1];
  assign cs_s   = sync_q[SYNC_STAGES-1][2];
  assign dc_s   = sync_q[SYNC_STAGES-1][3];
  assign res_s  = sync_q[SYNC_STAGES-1][4];

  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      sck_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {res, dc, cs, mosi, sck};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sck_prev_q <= sck_s;
    end
  end

  state_e          state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [6:0]      shreg_q, shreg_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            byte_is_data_q, byte_is_data_d;
  logic            fb_we_q, fb_we_d;
  logic [AW-1:0]   fb_addr_q, fb_addr_d;
  logic [7:0]      fb_wdata_q, fb_wdata_d;
  logic            display_on_q, display_on_d;
  logic [1:0]      addr_mode_q, addr_mode_d;
  logic [CW-1:0]   col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0]   page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic            fd_pend_q, fd_pend_d;
  logic            frame_done_q, frame_done_d;

  logic [7:0]      new_byte;
  logic            col_wrap, page_wrap;
  logic [CW-1:0]   col_next;
  logic [PW-1:0]   page_next;

  assign new_byte  = {shreg_q, mosi_s};
  assign col_wrap  = (col_q == col_end_q) || (col_q == CW'(COLS - 1));
  assign page_wrap = (page_q == page_end_q) || (page_q == PW'(PAGES - 1));
  assign col_next  = col_wrap ? col_start_q : col_q + CW'(1);
  assign page_next = page_wrap ? page_start_q : page_q + PW'(1);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    bitcnt_d       = bitcnt_q;
    shreg_d        = shreg_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_wdata_d     = fb_wdata_q;
    display_on_d   = display_on_q;
    addr_mode_d    = addr_mode_q;
    col_d          = col_q;
    col_start_d    = col_start_q;
    col_end_d      = col_end_q;
    page_d         = page_q;
    page_start_d   = page_start_q;
    page_end_d     = page_end_q;
    fd_pend_d      = 1'b0;
    // frame_done trails the wrapping write by one cycle
    frame_done_d   = fd_pend_q;

    if (cs_s) begin
      bitcnt_d = '0;
    end else if (sck_rise) begin
      shreg_d  = new_byte[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        byte_valid_d   = 1'b1;
        byte_data_d    = new_byte;
        byte_is_data_d = dc_s;
        if (dc_s) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = AW'({page_q, col_q});
          fb_wdata_d = new_byte;
          case (addr_mode_q)
            2'd0: begin
              col_d = col_next;
              if (col_wrap) page_d = page_next;
              fd_pend_d = col_wrap & page_wrap;
            end
            2'd1: begin
              page_d = page_next;
              if (page_wrap) col_d = col_next;
              fd_pend_d = col_wrap & page_wrap;
            end
            default: col_d = col_next;
          endcase
        end else begin
          case (state_q)
            ST_CMD: begin
              case (new_byte)
                8'hAE: display_on_d = 1'b0;
                8'hAF: display_on_d = 1'b1;
                8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8,
                8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                  op_d    = new_byte;
                  state_d = ST_ARG1;
                end
                default: ;
              endcase
            end
            ST_ARG1: begin
              state_d = ST_CMD;
              if (op_q == 8'h20) begin
                addr_mode_d = (new_byte[1:0] == 2'd3) ? 2'd2 : new_byte[1:0];
              end else if (op_q == 8'h21) begin
                col_start_d = new_byte[CW-1:0];
                state_d     = ST_ARG2;
              end else if (op_q == 8'h22) begin
                page_start_d = new_byte[PW-1:0];
                state_d      = ST_ARG2;
              end
            end
            ST_ARG2: begin
              state_d = ST_CMD;
              if (op_q == 8'h21) begin
                col_end_d = new_byte[CW-1:0];
                col_d     = col_start_q;
              end else begin
                page_end_d = new_byte[PW-1:0];
                page_d     = page_start_q;
              end
            end
            default: state_d = ST_CMD;
          endcase
        end
      end
    end

    // Synchronized panel reset behaves like the async reset, synchronously
    if (!res_s) begin
      state_d        = ST_CMD;
      op_d           = '0;
      bitcnt_d       = '0;
      shreg_d        = '0;
      byte_valid_d   = 1'b0;
      byte_data_d    = '0;
      byte_is_data_d = 1'b0;
      fb_we_d        = 1'b0;
      fb_addr_d      = '0;
      fb_wdata_d     = '0;
      display_on_d   = 1'b0;
      addr_mode_d    = 2'd2;
      col_d          = '0;
      col_start_d    = '0;
      col_end_d      = '1;
      page_d         = '0;
      page_start_d   = '0;
      page_end_d     = '1;
      fd_pend_d      = 1'b0;
      frame_done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_CMD;
      op_q           <= '0;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      byte_is_data_q <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      fb_wdata_q     <= '0;
      display_on_q   <= 1'b0;
      addr_mode_q    <= 2'd2;
      col_q          <= '0;
      col_start_q    <= '0;
      col_end_q      <= '1;
      page_q         <= '0;
      page_start_q   <= '0;
      page_end_q     <= '1;
      fd_pend_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_wdata_q     <= fb_wdata_d;
      display_on_q   <= display_on_d;
      addr_mode_q    <= addr_mode_d;
      col_q          <= col_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      page_q         <= page_d;
      page_start_q   <= page_start_d;
      page_end_q     <= page_end_d;
      fd_pend_q      <= fd_pend_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_wdata     = fb_wdata_q;
  assign display_on   = display_on_q;
  assign addr_mode    = addr_mode_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: drives SPI bytes on the pins, logs
// byte/write/frame strobes from a monitor and compares against hand-computed
// expectations.

module tb_oled_spi_receiver;

  logic       clk = 1'b0;
  logic       reset, sck, mosi, cs, dc, res;
  logic       byte_valid, byte_is_data, fb_we, display_on, frame_done;
  logic [7:0] byte_data, fb_wdata;
  logic [8:0] fb_addr;
  logic [1:0] addr_mode;

  int tests_run = 0;
  int tests_failed = 0;

  // Monitor logs
  logic [7:0] bv_data_q[$];
  logic       bv_isd_q[$];
  logic [8:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         fd_at_q[$];   // number of writes seen when frame_done fired
  int         wr_count = 0;

  always #5 clk = ~clk;

  oled_spi_receiver #(
    .COLS(128),
    .PAGES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sck(sck),
    .mosi(mosi),
    .cs(cs),
    .dc(dc),
    .res(res),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_is_data(byte_is_data),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_wdata(fb_wdata),
    .display_on(display_on),
    .addr_mode(addr_mode),
    .frame_done(frame_done)
  );

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_at_q.push_back(wr_count);
    if (byte_valid === 1'b1) begin
      bv_data_q.push_back(byte_data);
      bv_isd_q.push_back(byte_is_data);
    end
    if (fb_we === 1'b1) begin
      wr_addr_q.push_back(fb_addr);
      wr_data_q.push_back(fb_wdata);
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_logs();
    bv_data_q.delete();
    bv_isd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    fd_at_q.delete();
    wr_count = 0;
  endtask

  // Sends the top nbits of b, MSB first; sck half period of 5 clk periods.
  task automatic send_bits(input logic [7:0] b, input logic is_data, input int nbits);
    logic [7:0] v;
    v = b;
    @(negedge clk);
    cs = 1'b0;
    dc = is_data;
    for (int i = 0; i < nbits; i++) begin
      mosi = v[7];
      v = {v[6:0], 1'b0};
      wait_clk(5);
      sck = 1'b1;
      wait_clk(5);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data);
    send_bits(b, is_data, 8);
  endtask

  task automatic pulse_res();
    @(negedge clk);
    res = 1'b0;
    wait_clk(6);
    res = 1'b1;
    wait_clk(6);
  endtask

  initial begin
    reset = 1'b0;
    res   = 1'b1;
    cs    = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    dc    = 1'b0;
    wait_clk(4);

    // Reset state
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_is_data", byte_is_data, 1'b0);
    check("rst_fb_we", fb_we, 1'b0);
    check("rst_fb_addr", fb_addr, 9'd0);
    check("rst_fb_wdata", fb_wdata, 8'h00);
    check("rst_display_on", display_on, 1'b0);
    check("rst_addr_mode", addr_mode, 2'd2);
    check("rst_frame_done", frame_done, 1'b0);
    reset = 1'b1;
    wait_clk(6);

    // Display on
    clear_logs();
    send_byte(8'hAF, 1'b0);
    wait_clk(10);
    check("t1_bv_count", bv_data_q.size(), 1);
    check("t1_byte_data", bv_data_q[0], 8'hAF);
    check("t1_byte_is_data", bv_isd_q[0], 1'b0);
    check("t1_display_on", display_on, 1'b1);
    check("t1_no_write", wr_count, 0);

    // Horizontal full frame
    send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    wait_clk(10);
    check("t2_addr_mode", addr_mode, 2'd0);
    clear_logs();
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
    wait_clk(10);
    check("t2_wr_count", wr_addr_q.size(), 512);
    for (int i = 0; i < 512; i++) begin
      check("t2_addr", wr_addr_q[i], 32'(i));
      check("t2_wdata", wr_data_q[i], 32'(i % 256));
    end
    check("t2_fd_count", fd_at_q.size(), 1);
    check("t2_fd_after_write", fd_at_q[0], 512);
    check("t2_bv_isdata", bv_isd_q[0], 1'b1);
    send_byte(8'h5A, 1'b1);
    wait_clk(10);
    check("t2_wrap_addr", wr_addr_q[512], 9'd0);

    // Vertical window cols 16..17, pages 1..2
    send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    wait_clk(10);
    check("t3_addr_mode", addr_mode, 2'd1);
    clear_logs();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1);
    wait_clk(10);
    check("t3_wr_count", wr_addr_q.size(), 5);
    check("t3_addr0", wr_addr_q[0], 9'd144);
    check("t3_addr1", wr_addr_q[1], 9'd272);
    check("t3_addr2", wr_addr_q[2], 9'd145);
    check("t3_addr3", wr_addr_q[3], 9'd273);
    check("t3_addr4", wr_addr_q[4], 9'd144);
    check("t3_wdata2", wr_data_q[2], 8'hC2);
    check("t3_fd_count", fd_at_q.size(), 1);
    check("t3_fd_after_write", fd_at_q[0], 4);

    // Page mode, cols 126..127 on page 0
    send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
    wait_clk(10);
    check("t4_addr_mode", addr_mode, 2'd2);
    clear_logs();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h11 * (i + 1)), 1'b1);
    wait_clk(10);
    check("t4_wr_count", wr_addr_q.size(), 3);
    check("t4_addr0", wr_addr_q[0], 9'd126);
    check("t4_addr1", wr_addr_q[1], 9'd127);
    check("t4_addr2", wr_addr_q[2], 9'd126);
    check("t4_fd_count", fd_at_q.size(), 0);

    // Partial byte discard and argument consumption
    pulse_res();
    check("t5_res_display_off", display_on, 1'b0);
    clear_logs();
    send_byte(8'hA5, 1'b0);
    send_bits(8'hFF, 1'b0, 5);
    wait_clk(4);
    cs = 1'b1;
    wait_clk(10);
    send_byte(8'h81, 1'b0);
    send_byte(8'hAF, 1'b0);
    wait_clk(10);
    check("t5_bv_count", bv_data_q.size(), 3);
    check("t5_byte0", bv_data_q[0], 8'hA5);
    check("t5_byte1", bv_data_q[1], 8'h81);
    check("t5_byte2", bv_data_q[2], 8'hAF);
    check("t5_display_on", display_on, 1'b0);
    send_byte(8'hAF, 1'b0);
    wait_clk(10);
    check("t5_display_on_after", display_on, 1'b1);

    // Mid-byte soft reset
    send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b1);
    wait_clk(10);
    check("t6_pre_addr", fb_addr, 9'd2);
    check("t6_pre_mode", addr_mode, 2'd0);
    clear_logs();
    send_bits(8'hF0, 1'b1, 4);
    pulse_res();
    check("t6_fb_addr", fb_addr, 9'd0);
    check("t6_addr_mode", addr_mode, 2'd2);
    check("t6_display_on", display_on, 1'b0);
    check("t6_no_stale_bv", bv_data_q.size(), 0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h4D, 1'b1);
    send_byte(8'hAF, 1'b0);
    wait_clk(10);
    check("t6_bv_count", bv_data_q.size(), 3);
    check("t6_byte0", bv_data_q[0], 8'h3C);
    check("t6_wr_addr0", wr_addr_q[0], 9'd0);
    check("t6_wr_addr1", wr_addr_q[1], 9'd1);
    check("t6_is_data", byte_is_data, 1'b0);
    check("t6_display_on", display_on, 1'b1);

    // Asynchronous reset between clock edges
    send_byte(8'h99, 1'b1);
    wait_clk(10);
    check("t7_pre_addr", fb_addr, 9'd2);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("t7_byte_data", byte_data, 8'h00);
    check("t7_byte_is_data", byte_is_data, 1'b0);
    check("t7_fb_addr", fb_addr, 9'd0);
    check("t7_fb_wdata", fb_wdata, 8'h00);
    check("t7_display_on", display_on, 1'b0);
    check("t7_addr_mode", addr_mode, 2'd2);
    check("t7_byte_valid", byte_valid, 1'b0);
    wait_clk(3);
    reset = 1'b1;
    cs = 1'b1;
    wait_clk(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
